ls_byte_packer: RTL and testbench

- Bit-stream packer directly downstream of the encoder top's variable-length code output (cod_32 / len_32 with its enable).
- Concatenates right-aligned codewords MSB-first into a byte stream and applies JPEG-LS bit stuffing: after every 0xFF byte, a 0 bit is inserted as the MSB of the next byte.
- Output is a byte-wide valid/ready stream with a flush sequence that closes a scan.

---
 rtl/ls_byte_packer.sv | 149 ++++++++++++++
 tb/tb_ls_byte_packer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ls_byte_packer.sv
// JPEG-LS bit-stream packer: appends right-aligned codewords MSB-first into an
// accumulator and emits a byte stream with optional 0-bit stuffing after 0xFF.
module ls_byte_packer #(
    parameter int ACC_W    = 64,
    parameter int IN_W     = 32,
    parameter int STUFF_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [IN_W-1:0] cod_32,
    input  logic [5:0]      len_32,
    input  logic            flush,
    output logic            in_ready,
    output logic [7:0]      byte_out,
    output logic            byte_valid,
    input  logic            byte_ready,
    output logic            flush_done
);

    localparam int CNT_W = $clog2(ACC_W + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PAD,
        ST_TAIL,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               last_ff_q, last_ff_d;
    logic [7:0]         byte_out_q, byte_out_d;
    logic               byte_valid_q, byte_valid_d;
    logic               flush_done_q, flush_done_d;

    logic               reg_free;
    logic               stuffed;
    logic [CNT_W-1:0]   need;
    logic [CNT_W-1:0]   len_sat;
    logic               accept;
    logic               emit_full;
    logic               emit_pad;
    logic               emit;
    logic [7:0]         emit_byte;
    logic [ACC_W-1:0]   acc_shift;
    logic [CNT_W-1:0]   cnt_base;
    logic [IN_W-1:0]    code_mask;
    logic [ACC_W-1:0]   code_placed;

    assign reg_free = !byte_valid_q || byte_ready;
    assign stuffed  = (STUFF_EN != 0) && last_ff_q;
    assign need     = stuffed ? CNT_W'(7) : CNT_W'(8);
    assign len_sat  = (CNT_W'(len_32) > CNT_W'(IN_W)) ? CNT_W'(IN_W) : CNT_W'(len_32);
    assign in_ready = (state_q == ST_RUN) && (bit_cnt_q <= CNT_W'(ACC_W - IN_W));
    assign accept   = en && in_ready && (len_sat != '0);

    // Pad emission only happens while flushing: the tail is zero-filled because
    // bits below the valid region of the accumulator are always zero.
    assign emit_full = reg_free && (bit_cnt_q >= need)
                       && ((state_q == ST_RUN) || (state_q == ST_PAD));
    assign emit_pad  = reg_free && (state_q == ST_PAD)
                       && (bit_cnt_q != '0) && (bit_cnt_q < need);
    assign emit      = emit_full || emit_pad;

    assign emit_byte = stuffed ? {1'b0, acc_q[ACC_W-1 -: 7]} : acc_q[ACC_W-1 -: 8];
    assign acc_shift = emit ? (acc_q << need) : acc_q;
    assign cnt_base  = emit_full ? (bit_cnt_q - need) : (emit_pad ? '0 : bit_cnt_q);

    // New bits land directly below whatever remains after this cycle's emit.
    assign code_mask   = {IN_W{1'b1}} >> (CNT_W'(IN_W) - len_sat);
    assign code_placed = (ACC_W'(cod_32 & code_mask) << (CNT_W'(ACC_W) - len_sat)) >> cnt_base;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_shift;
        bit_cnt_d    = cnt_base;
        last_ff_d    = last_ff_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = reg_free ? 1'b0 : byte_valid_q;
        flush_done_d = 1'b0;

        if (accept) begin
            acc_d     = acc_shift | code_placed;
            bit_cnt_d = cnt_base + len_sat;
        end

        if (emit) begin
            byte_out_d   = emit_byte;
            byte_valid_d = 1'b1;
            last_ff_d    = (emit_byte == 8'hFF);
        end

        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_PAD;
                end
            end
            ST_PAD: begin
                if (reg_free && (bit_cnt_q == '0)) begin
                    state_d = stuffed ? ST_TAIL : ST_DONE;
                end
            end
            ST_TAIL: begin
                if (reg_free) begin
                    byte_out_d   = 8'h00;
                    byte_valid_d = 1'b1;
                    last_ff_d    = 1'b0;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!byte_valid_q) begin
                    flush_done_d = 1'b1;
                    last_ff_d    = 1'b0;
                    state_d      = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            acc_q        <= '0;
            bit_cnt_q    <= '0;
            last_ff_q    <= 1'b0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            bit_cnt_q    <= bit_cnt_d;
            last_ff_q    <= last_ff_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign flush_done = flush_done_q;

endmodule

// File: tb/tb_ls_byte_packer.sv
// Scoreboard bench for ls_byte_packer: stimulus queues expected bytes, a
// negedge monitor pops and compares each byte the packer hands off.
module tb_ls_byte_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [31:0] cod_32 = '0;
    logic [5:0]  len_32 = '0;
    logic        flush = 1'b0;
    logic        byte_ready = 1'b1;
    logic        in_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        flush_done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_b;

    ls_byte_packer #(.ACC_W(64), .IN_W(32), .STUFF_EN(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .cod_32     (cod_32),
        .len_32     (len_32),
        .flush      (flush),
        .in_ready   (in_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .flush_done (flush_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every handed-off byte must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && byte_valid && byte_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %02h expected none", byte_out);
            end else begin
                exp_b = sb.pop_front();
                check("byte", 32'(byte_out), 32'(exp_b));
            end
        end
        if (!reset && flush_done) begin
            done_cnt++;
            check("flush_done_after_drain", 32'(sb.size()), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] c, input logic [5:0] l, input logic f);
        int n;
        n = 0;
        cod_32 = c;
        len_32 = l;
        en     = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        flush = f;
        tick();
        en     = 1'b0;
        flush  = 1'b0;
        cod_32 = '0;
        len_32 = '0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_done(input int start);
        int n;
        n = 0;
        while (done_cnt == start && n < 100) begin
            tick();
            n++;
        end
        if (done_cnt == start) begin
            checks++;
            errors++;
            $display("FAIL flush_done_timeout: got no pulse expected one");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || byte_valid) && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0 || byte_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending %0d expected 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int start;
        #1;
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_byte_out", 32'(byte_out), 32'h00);
        check("rst_flush_done", 32'(flush_done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        reset = 1'b0;
        tick();

        // Four plain bytes, first one registered the cycle after its accept
        sb.push_back(8'h12); sb.push_back(8'h34); sb.push_back(8'h56); sb.push_back(8'h78);
        send(32'h12, 6'd8, 1'b0);
        check("latency_pre", 32'(byte_valid), 32'd0);
        send(32'h34, 6'd8, 1'b0);
        check("latency_first", 32'(byte_valid), 32'd1);
        check("latency_first_byte", 32'(byte_out), 32'h12);
        send(32'h56, 6'd8, 1'b0);
        send(32'h78, 6'd8, 1'b0);
        drain();

        // Stuffing inside the stream, padded last byte, no trailing 00
        sb.push_back(8'hFF); sb.push_back(8'h7F); sb.push_back(8'h80);
        start = done_cnt;
        send(32'hFFFF, 6'd16, 1'b0);
        do_flush();
        wait_done(start);
        drain();

        // Scan ending on FF gets an explicit 00 tail byte
        sb.push_back(8'hFF); sb.push_back(8'h00);
        start = done_cnt;
        send(32'hFF, 6'd8, 1'b0);
        do_flush();
        wait_done(start);
        drain();

        // Back-pressure: in_ready drops once bit_cnt reaches 56
        byte_ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            sb.push_back(8'hAA); sb.push_back(8'hBB); sb.push_back(8'hCC); sb.push_back(8'hDD);
        end
        send(32'hAABBCCDD, 6'd32, 1'b0);
        send(32'hAABBCCDD, 6'd32, 1'b0);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        tick(); tick();
        check("bp_hold_valid", 32'(byte_valid), 32'd1);
        check("bp_hold_byte", 32'(byte_out), 32'hAA);
        byte_ready = 1'b1;
        drain();

        // Short codeword with flush in the same cycle
        sb.push_back(8'hA0);
        start = done_cnt;
        send(32'h5, 6'd3, 1'b1);
        check("pad_in_ready", 32'(in_ready), 32'd0);
        wait_done(start);
        check("run_in_ready", 32'(in_ready), 32'd1);

        // Masking, len 0 no-op, len > 32 saturation
        sb.push_back(8'h0F);
        send(32'hFFFFFFF0, 6'd4, 1'b0);
        send(32'h1, 6'd0, 1'b0);
        send(32'hF, 6'd4, 1'b0);
        sb.push_back(8'h12); sb.push_back(8'h34); sb.push_back(8'h56); sb.push_back(8'h78);
        send(32'h12345678, 6'd40, 1'b0);
        drain();

        // Reset mid-stream discards buffered bits and the held byte
        byte_ready = 1'b0;
        send(32'h0ABCDEF1, 6'd28, 1'b0);
        tick(); tick();
        check("pre_rst_valid", 32'(byte_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(byte_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        reset = 1'b0;
        byte_ready = 1'b1;
        tick();
        sb.push_back(8'h5A);
        send(32'h5A, 6'd8, 1'b0);
        drain();
        tick(); tick();

        check("done_pulses", 32'(done_cnt), 32'd3);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
